// File: rtl/control_unit_mc_if.sv
// Control-unit interface bundle.
// Groups every non-clock/reset signal of the multi-core control unit.
//   master : the control unit (samples start/ir/z/core_en/mem_ready and
//            drives the strobes, bus select, ALU mode and handshakes)
//   slave  : the datapath / memory side (drives the inputs and observes
//            the strobes)
interface control_unit_mc_if #(
  parameter int IR_W      = 8,
  parameter int NUM_REGS  = 12,
  parameter int NUM_CORES = 4
);
  logic                 start;
  logic [IR_W-1:0]      ir;
  logic [NUM_CORES-1:0] z;
  logic [NUM_CORES-1:0] core_en;
  logic                 mem_ready;
  logic                 busy;
  logic                 end_op;
  logic                 illegal;
  logic                 im_rd;
  logic                 ir_ld;
  logic                 pc_inc;
  logic                 pc_ld;
  logic                 dm_rd;
  logic                 dm_wr;
  logic [3:0]           alu_mode;
  logic [3:0]           bus_ld;
  logic [NUM_REGS-1:0]  write_en;
  logic [NUM_REGS-1:0]  inc;
  logic [NUM_REGS-1:0]  clr;
  logic [NUM_CORES-1:0] core_start;

  modport master (
    input  start, ir, z, core_en, mem_ready,
    output busy, end_op, illegal, im_rd, ir_ld, pc_inc, pc_ld, dm_rd, dm_wr,
           alu_mode, bus_ld, write_en, inc, clr, core_start
  );

  modport slave (
    output start, ir, z, core_en, mem_ready,
    input  busy, end_op, illegal, im_rd, ir_ld, pc_inc, pc_ld, dm_rd, dm_wr,
           alu_mode, bus_ld, write_en, inc, clr, core_start
  );
endinterface

// File: rtl/control_unit_mc.sv
// Multi-core control unit of the matrix-multiplier processor.
// Sequences IDLE -> FETCH -> DECODE -> EXEC (-> WB for ALU ops) and decodes
// the register strobes, bus source, ALU mode and memory handshakes.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (priority over everything)
//   cu  - control_unit_mc_if.master: start/ir/z/core_en/mem_ready in,
//         busy/end_op/illegal/im_rd/ir_ld/pc_inc/pc_ld/dm_rd/dm_wr/
//         alu_mode/bus_ld/write_en/inc/clr/core_start out
// The state register is the only storage; every output is a combinational
// decode of the state and ir.
module control_unit_mc #(
  parameter int IR_W      = 8,
  parameter int NUM_REGS  = 12,
  parameter int NUM_CORES = 4
) (
  input  logic                clk,
  input  logic                rst,
  control_unit_mc_if.master   cu
);

  localparam int RI_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t state_q, state_d;

  logic [3:0]          opcode;
  logic [RI_W-1:0]     r;
  logic                r_ok;
  logic                uses_r;
  logic                all_z;
  logic [NUM_REGS-1:0] r_onehot;
  logic [3:0]          reg_src;
  logic [3:0]          alu_sel;

  assign opcode  = cu.ir[IR_W-1 -: 4];
  assign r       = cu.ir[RI_W-1:0];
  assign r_ok    = int'(r) < NUM_REGS;
  // Opcodes 0x1..0xB carry a register operand; NOP, END and the undefined
  // opcodes do not, so their low bits are never range-checked.
  assign uses_r  = (opcode >= 4'h1) && (opcode <= 4'hB);
  assign reg_src = 4'd4 + 4'(r);
  assign alu_sel = opcode - 4'd4;

  // Jump condition: every enabled core reports zero. An empty mask never
  // satisfies it, so JMPNZ is taken when no core is enabled.
  assign all_z = (cu.core_en != '0) && ((cu.z & cu.core_en) == cu.core_en);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
    assign r_onehot[gi] = (r == RI_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cu.busy       = (state_q != S_IDLE);
    cu.end_op     = 1'b0;
    cu.illegal    = 1'b0;
    cu.im_rd      = 1'b0;
    cu.ir_ld      = 1'b0;
    cu.pc_inc     = 1'b0;
    cu.pc_ld      = 1'b0;
    cu.dm_rd      = 1'b0;
    cu.dm_wr      = 1'b0;
    cu.alu_mode   = 4'd0;
    cu.bus_ld     = 4'd0;
    cu.write_en   = '0;
    cu.inc        = '0;
    cu.clr        = '0;
    cu.core_start = '0;

    case (state_q)
      S_IDLE: begin
        if (cu.start) state_d = S_FETCH;
      end

      S_FETCH: begin
        cu.im_rd = 1'b1;
        if (cu.mem_ready) begin
          cu.ir_ld  = 1'b1;
          cu.pc_inc = 1'b1;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        state_d = S_FETCH;
        if (uses_r && !r_ok) begin
          // Out-of-range operand: flag it and drop all strobes.
          cu.illegal = 1'b1;
        end else begin
          case (opcode)
            4'h1: begin
              cu.dm_rd = 1'b1;
              if (cu.mem_ready) begin
                cu.bus_ld   = 4'd1;
                cu.write_en = r_onehot;
              end else begin
                state_d = S_EXEC;
              end
            end
            4'h2: begin
              cu.dm_wr  = 1'b1;
              cu.bus_ld = reg_src;
              if (!cu.mem_ready) state_d = S_EXEC;
            end
            4'h3: begin
              cu.bus_ld      = reg_src;
              cu.write_en[0] = 1'b1;
            end
            4'h4: begin
              cu.bus_ld   = 4'd4;
              cu.write_en = r_onehot;
            end
            4'h5, 4'h6, 4'h7: begin
              cu.alu_mode   = alu_sel;
              cu.bus_ld     = reg_src;
              cu.core_start = cu.core_en;
              state_d       = S_WB;
            end
            4'h8: cu.inc = r_onehot;
            4'h9: cu.clr = r_onehot;
            4'hA, 4'hB: begin
              if (all_z == (opcode == 4'hA)) begin
                cu.pc_ld  = 1'b1;
                cu.bus_ld = reg_src;
              end
            end
            4'hC, 4'hD, 4'hE: cu.illegal = 1'b1;
            4'hF: begin
              cu.end_op = 1'b1;
              state_d   = S_IDLE;
            end
            default: ;  // NOP
          endcase
        end
      end

      S_WB: begin
        // ir still holds the ALU instruction, so the mode is re-derived.
        cu.alu_mode    = alu_sel;
        cu.bus_ld      = 4'd3;
        cu.write_en[0] = 1'b1;
        state_d        = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Parametrised, multi-core successor to the single-core control unit of the matrix-multiplier processor.
- Sequences fetch/decode/execute for the shared datapath and drives register strobes, bus source select, ALU mode and memory handshakes.
- Broadcasts ALU ops to NUM_CORES parallel cores and evaluates jumps on the combined z flags of the enabled cores.
- Adds start/busy control and mem_ready wait-states for the instruction and data memories.

Parameters:
IR_W, 8, instruction width; opcode = ir[IR_W-1:IR_W-4], operand r = ir[RI_W-1:0], RI_W = clog2(NUM_REGS); IR_W-4 >= RI_W required.
NUM_REGS, 12, number of datapath registers (max 12); register 0 is ACC.
NUM_CORES, 4, number of parallel ALU cores.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin program execution from IDLE
ir  in  IR_W  instruction register contents (valid from DECODE onward)
z  in  NUM_CORES  per-core ALU zero flags
core_en  in  NUM_CORES  active-core mask
mem_ready  in  1  current IM/DM access completes this cycle
busy  out  1  high in every state except IDLE
end_op  out  1  one-cycle pulse on END
illegal  out  1  one-cycle pulse on undefined opcode
im_rd  out  1  instruction memory read
ir_ld  out  1  load IR from IM data
pc_inc  out  1  PC <= PC+1
pc_ld  out  1  PC <= bus
dm_rd  out  1  data memory read
dm_wr  out  1  data memory write
alu_mode  out  4  0 idle, 1 add, 2 sub, 3 mul
bus_ld  out  4  bus source: 0 none, 1 DM data, 2 IM data, 3 ALU result, 4+k register k
write_en  out  NUM_REGS  one-hot register load
inc  out  NUM_REGS  one-hot register increment
clr  out  NUM_REGS  one-hot register clear
core_start  out  NUM_CORES  per-core ALU start

Behaviour:
- All outputs are a combinational decode of the registered state and ir; the state register is the only storage.
- States: IDLE, FETCH, DECODE, EXEC, WB.
- IDLE: all outputs 0. start=1 -> FETCH. start is ignored in any other state.
- FETCH: im_rd=1, held until mem_ready. In the mem_ready cycle also assert ir_ld=1 and pc_inc=1, then -> DECODE.
- DECODE: outputs 0, busy=1; -> EXEC.
- EXEC, by opcode:
  - 0x0 NOP: no strobes; -> FETCH.
  - 0x1 LOAD r: dm_rd=1 until mem_ready. In the ready cycle bus_ld=1, write_en[r]=1; -> FETCH.
  - 0x2 STORE r: dm_wr=1, bus_ld=4+r, both held until mem_ready; -> FETCH.
  - 0x3 MOVA r: bus_ld=4+r, write_en[0]=1. 0x4 MOVR r: bus_ld=4, write_en[r]=1. Both 1 cycle.
  - 0x5/0x6/0x7 ADD/SUB/MUL r: alu_mode=1/2/3, bus_ld=4+r, core_start=core_en; -> WB.
  - WB: alu_mode held, bus_ld=3, write_en[0]=1; -> FETCH.
  - 0x8 INC r: inc[r]=1. 0x9 CLR r: clr[r]=1. Both 1 cycle.
  - 0xA JMPZ r: taken iff core_en!=0 and (z & core_en)==core_en. Taken: pc_ld=1, bus_ld=4+r. Not taken: no strobes. -> FETCH.
  - 0xB JMPNZ r: exact complement of the JMPZ condition; same strobes when taken.
  - 0xF END: end_op=1 for one cycle; -> IDLE.
  - 0xC-0xE: illegal=1 for one cycle, otherwise behaves as NOP.
- Operand r >= NUM_REGS: treated as illegal (illegal=1), no register strobes.
- Write strobes are one-hot; at most one of write_en/inc/clr is non-zero per cycle.
- Instruction latency with mem_ready tied high: FETCH+DECODE+EXEC = 3 cycles; ALU ops 4 cycles.
- mem_ready outside FETCH/LOAD/STORE is ignored.
- Reset: rst=1 at any edge -> IDLE next cycle, all outputs 0 including an in-flight dm_wr/im_rd; rst has priority over start.

Test Plan:
- Reset then start, ir=0x00, mem_ready=1 -> im_rd/ir_ld/pc_inc in cycle 1, DECODE in cycle 2, EXEC in cycle 3 with no strobes, busy=1 throughout, back to FETCH.
- ir=0x12 (LOAD r2), mem_ready low 3 cycles then high -> dm_rd held 4 cycles; write_en=12'h004 with bus_ld=1 only in the ready cycle.
- ir=0x53 (ADD r3), core_en=4'b1011 -> EXEC: alu_mode=1, bus_ld=7, core_start=4'b1011; WB: bus_ld=3, write_en=12'h001.
- ir=0xA5, core_en=4'b0011, z=4'b0111 -> pc_ld=1, bus_ld=9. Repeat with z=4'b0110 -> no pc_ld. ir=0xB5 with core_en=0 -> pc_ld=1.
- ir=0x2E (STORE r14) -> illegal pulse, no strobes. ir=0xF0 -> end_op single pulse, busy=0 next cycle, start ignored while busy.
- rst asserted during STORE with dm_wr=1 -> dm_wr=0, busy=0 next cycle; the following start begins in FETCH.
